// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipe; all control outputs are combinational from state + stage info.
// Memory wait outranks branch flush, which outranks RAW stalls; counters and the timeout flag are registered.
module pipe_hazard_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int R0_ZERO     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_EN,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              two_src,
  input  logic [ADDR_W-1:0] dest_EXE,
  input  logic              WB_EN_EXE,
  input  logic              MEM_R_EN_EXE,
  input  logic [ADDR_W-1:0] dest_MEM,
  input  logic              WB_EN_MEM,
  input  logic              brTaken,
  input  logic              mem_req,
  input  logic              mem_busy,
  output logic              freeze_PC,
  output logic              freeze_IF_ID,
  output logic              flush_IF_ID,
  output logic              bubble_ID_EXE,
  output logic              freeze_EXE_MEM,
  output logic              bubble_MEM_WB,
  output logic              hazard_detected,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic [15:0]       stall_count,
  output logic              mem_timeout
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0]    FLUSH_LOAD = 3'(BR_PENALTY - 1);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t          state_q, state_d, pend_q, pend_d, eff_state;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic [15:0]     stall_q, stall_d;

  logic            m1e, m2e, m1m, m2m, raw;
  logic            mem_wait, flushing, hazard;
  logic [1:0]      sel1, sel2;

  function automatic logic match(input logic [ADDR_W-1:0] a,
                                 input logic [ADDR_W-1:0] d,
                                 input logic              en);
    return en && (a == d) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic exe_hit, input logic mem_hit,
                                         input logic exe_load);
    if (exe_hit && !exe_load) return 2'b01;
    if (mem_hit)              return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    m1e = match(src1, dest_EXE, WB_EN_EXE);
    m1m = match(src1, dest_MEM, WB_EN_MEM);
    m2e = two_src && match(src2, dest_EXE, WB_EN_EXE);
    m2m = two_src && match(src2, dest_MEM, WB_EN_MEM);

    if (forward_EN) begin
      raw  = MEM_R_EN_EXE && (m1e || m2e);
      sel1 = fwd_sel(m1e, m1m, MEM_R_EN_EXE);
      sel2 = fwd_sel(m2e, m2m, MEM_R_EN_EXE);
    end else begin
      raw  = m1e || m1m || m2e || m2m;
      sel1 = 2'b00;
      sel2 = 2'b00;
    end
  end

  // MEM_WAIT only marks the freeze; once memory is ready the pipe behaves as the state it interrupted.
  always_comb begin
    mem_wait  = mem_req && mem_busy;
    eff_state = (state_q == MEM_WAIT) ? pend_q : state_q;
    flushing  = !mem_wait && (brTaken || (eff_state == FLUSH));
    // The ID instruction is being squashed while flushing, so a RAW on it is moot.
    hazard    = !mem_wait && !flushing && raw;
  end

  always_comb begin
    state_d       = eff_state;
    pend_d        = pend_q;
    fcnt_d        = fcnt_q;
    tmo_cnt_d     = '0;
    mem_timeout_d = mem_timeout_q;

    if (mem_wait) begin
      state_d   = MEM_WAIT;
      pend_d    = eff_state;
      tmo_cnt_d = (tmo_cnt_q == TMO_LIMIT) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
      if (tmo_cnt_d == TMO_LIMIT) mem_timeout_d = 1'b1;
    end else if (brTaken) begin
      fcnt_d  = FLUSH_LOAD;
      state_d = (BR_PENALTY > 1) ? FLUSH : RUN;
    end else if (eff_state == FLUSH) begin
      fcnt_d  = fcnt_q - 3'd1;
      state_d = (fcnt_q == 3'd1) ? RUN : FLUSH;
    end else begin
      state_d = RUN;
    end

    stall_d = stall_q;
    if ((mem_wait || hazard) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pend_q        <= RUN;
      fcnt_q        <= '0;
      tmo_cnt_q     <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      fcnt_q        <= fcnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
    end
  end

  assign freeze_PC       = !rst && (mem_wait || hazard);
  assign freeze_IF_ID    = !rst && (mem_wait || hazard);
  assign flush_IF_ID     = !rst && flushing;
  assign bubble_ID_EXE   = !rst && hazard;
  assign freeze_EXE_MEM  = !rst && mem_wait;
  assign bubble_MEM_WB   = !rst && mem_wait;
  assign hazard_detected = !rst && hazard;
  assign sel_src1        = rst ? 2'b00 : sel1;
  assign sel_src2        = rst ? 2'b00 : sel2;
  assign stall_count     = stall_q;
  assign mem_timeout     = mem_timeout_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forward sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It takes register-usage and write-back info from the ID, EXE and MEM stages, the branch-taken flag and the data-memory ready status. From these it drives freeze, flush and bubble enables for the PC and all pipe registers, plus the operand forwarding selects. It also exposes the hazard_detected flag consumed by the ID stage, a stall-cycle counter and a sticky memory-timeout error.

Parameters:
ADDR_W, 4, register-file address width (equals REG_FILE_ADDR_LEN)
BR_PENALTY, 1, cycles flush_IF_ID stays high per taken branch (1..7)
MEM_TIMEOUT, 255, max consecutive mem_busy cycles before mem_timeout is set
R0_ZERO, 1, 1 = address 0 is hardwired zero; it never forwards and never causes a hazard

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
forward_EN  in  1  1 = forwarding enabled; 0 = resolve every RAW hazard by stalling
src1  in  ADDR_W  ID-stage source 1 address
src2  in  ADDR_W  ID-stage source 2 address
two_src  in  1  ID instruction reads src2
dest_EXE  in  ADDR_W  destination of the instruction in EXE
WB_EN_EXE  in  1  EXE instruction writes the register file
MEM_R_EN_EXE  in  1  EXE instruction is a load
dest_MEM  in  ADDR_W  destination of the instruction in MEM
WB_EN_MEM  in  1  MEM instruction writes the register file
brTaken  in  1  branch resolved taken this cycle
mem_req  in  1  MEM stage is accessing data memory
mem_busy  in  1  data memory not ready
freeze_PC  out  1  hold PC
freeze_IF_ID  out  1  hold IF/ID register
flush_IF_ID  out  1  clear IF/ID register to NOP
bubble_ID_EXE  out  1  load NOP into ID/EXE
freeze_EXE_MEM  out  1  hold ID/EXE and EXE/MEM registers
bubble_MEM_WB  out  1  load NOP into MEM/WB
hazard_detected  out  1  RAW stall request to ID stage
sel_src1  out  2  forward select: 00 regfile, 01 MEM-stage result, 10 WB result
sel_src2  out  2  same encoding, for operand 2
stall_count  out  16  saturating count of stalled cycles
mem_timeout  out  1  sticky error flag

Behaviour:
- match(a,d,en) = en && a==d && !(R0_ZERO && a==0).
- Forwarding (combinational; valid only when forward_EN=1, otherwise selects are 00):
  - sel=01 if match(src,dest_EXE,WB_EN_EXE) and no load in EXE.
  - else sel=10 if match(src,dest_MEM,WB_EN_MEM).
  - else 00. EXE match has priority over MEM match.
  - src2 is only considered when two_src=1.
- RAW hazard (combinational):
  - forward_EN=1: a load in EXE whose dest matches src1, or src2 with two_src=1.
  - forward_EN=0: any EXE or MEM write-back match on a used source.
- FSM states: RUN, FLUSH, MEM_WAIT. Priority for the current cycle is mem wait > branch > RAW.
  - MEM_WAIT condition: mem_req && mem_busy, evaluated combinationally in any state.
    - Asserts freeze_PC, freeze_IF_ID, freeze_EXE_MEM and bubble_MEM_WB.
    - Suppresses flush and bubble_ID_EXE.
    - The next state is MEM_WAIT. On the first cycle with the condition false, the FSM returns to the pending state: FLUSH if a flush was in progress, else RUN.
  - Branch: brTaken in RUN or FLUSH asserts flush_IF_ID the same cycle and loads the flush counter with BR_PENALTY-1.
    - In FLUSH, flush_IF_ID stays high while the counter is non-zero; the counter decrements each non-frozen cycle.
    - The FSM returns to RUN when the counter reaches 0.
    - A new brTaken during FLUSH reloads the counter.
    - With BR_PENALTY=1, the FSM never leaves RUN.
  - RAW (no mem wait, no brTaken): hazard_detected=1, freeze_PC=1, freeze_IF_ID=1, bubble_ID_EXE=1.
  - brTaken together with RAW: the flush wins; hazard_detected=0.
- stall_count increments on every cycle where freeze_PC=1 and sticks at 16'hFFFF.
- Timeout counter:
  - Counts consecutive mem_busy cycles in MEM_WAIT and clears on leaving MEM_WAIT.
  - Reaching MEM_TIMEOUT sets mem_timeout, which is sticky until reset. The freeze continues.
- Reset (rst high, async):
  - State=RUN; flush, timeout and stall counters = 0; mem_timeout=0.
  - All freeze/flush/bubble/hazard outputs are forced to 0 and sel_src* to 00 while rst is high.
  - A reset during MEM_WAIT or FLUSH abandons the sequence; the pipeline resumes in RUN on the first edge after release.

Test Plan:
- forward_EN=1, dest_EXE=3, WB_EN_EXE=1, MEM_R_EN_EXE=0, src1=3, src2=3, two_src=1 -> sel_src1=01, sel_src2=01, hazard_detected=0.
- Load-use: MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=5, src2=5, two_src=1, held one cycle, then dest moves to MEM -> exactly 1 cycle of hazard/freeze_PC/bubble_ID_EXE, then sel_src2=10; stall_count=1.
- forward_EN=0, WB_EN_MEM=1, dest_MEM=2, src1=2 -> hazard_detected=1 and sel_src1=00; src1=0 with R0_ZERO=1 -> no hazard.
- BR_PENALTY=3, brTaken pulse together with a RAW condition -> flush_IF_ID high for 3 cycles, hazard_detected=0 in the brTaken cycle, FSM back to RUN.
- mem_req=1, mem_busy=1 for 4 cycles during FLUSH -> all freezes plus bubble_MEM_WB for 4 cycles, flush resumes afterwards, stall_count=4.
- mem_busy held for 255 cycles -> mem_timeout rises, stays high after busy drops, clears only on async rst asserted mid-cycle.
